// File: rtl/mem_responder_if.sv
// Request/response channel pair between the CPU-side arbiter and the memory
// responder. Both channels use a valid/ready handshake.
interface mem_responder_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  // response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  // requester side: issues requests, consumes responses
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // memory side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: services word-addressed reads/writes from an internal
// RAM and returns exactly one in-order response per accepted request, after a
// configurable latency and with a bounded number of outstanding requests.
module mem_responder #(
  parameter int          DEPTH_WORDS     = 4096,
  parameter logic [31:0] BASE            = 32'h8000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  mem
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam int          CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int          PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          FD    = 1 << PW;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0]   ram [DEPTH_WORDS];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          acc;
  logic          pop;

  logic          vld_p0;
  logic [31:0]   data_p0;
  logic          push_vld;
  logic [31:0]   push_data;

  logic [31:0]   fifo [FD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] fcnt_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ready_q;

  // Unsigned offset: addresses below BASE wrap high and fall out of range.
  assign off      = mem.req_addr - BASE;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[AW+1:2];

  assign acc = mem.req_valid & ready_q;
  assign pop = mem.resp_valid & mem.resp_ready;

  // ---- stage p0: acceptance edge, RAM sampled here ----
  assign vld_p0  = acc;
  assign data_p0 = (in_range && !mem.req_we) ? ram[idx] : 32'h0;

  // RAM write on the acceptance edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (acc && mem.req_we && in_range)
      ram[idx] <= merge_be(ram[idx], mem.req_wdata, mem.req_be);
  end

  // ---- stages p1..p(LATENCY-1): delay line ahead of the response FIFO ----
  generate
    if (LATENCY == 1) begin : g_nodly
      assign push_vld  = vld_p0;
      assign push_data = data_p0;
    end else begin : g_dly
      logic        vld_pn  [LATENCY-1];
      logic [31:0] data_pn [LATENCY-1];

      // Valid bits of the delay line; cleared so reset drops in-flight responses.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LATENCY-1; i++) vld_pn[i] <= 1'b0;
        end else begin
          vld_pn[0] <= vld_p0;
          for (int i = 1; i < LATENCY-1; i++) vld_pn[i] <= vld_pn[i-1];
        end
      end

      // Data of the delay line; meaningful only where the matching valid is set.
      always_ff @(posedge clk) begin
        data_pn[0] <= data_p0;
        for (int i = 1; i < LATENCY-1; i++) data_pn[i] <= data_pn[i-1];
      end

      assign push_vld  = vld_pn[LATENCY-2];
      assign push_data = data_pn[LATENCY-2];
    end
  endgenerate

  // ---- response FIFO: sized by MAX_OUTSTANDING so it cannot overflow ----
  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_vld) fifo[wr_ptr] <= push_data;
  end

  // Next-state occupancy of the FIFO and of the outstanding counter.
  always_comb begin
    fcnt_nxt = fcnt;
    if (push_vld && !pop)      fcnt_nxt = fcnt + 1'b1;
    else if (!push_vld && pop) fcnt_nxt = fcnt - 1'b1;
    cnt_nxt = cnt;
    if (acc && !pop)           cnt_nxt = cnt + 1'b1;
    else if (!acc && pop)      cnt_nxt = cnt - 1'b1;
  end

  // FIFO pointers, counters and the registered request-ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fcnt    <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      fcnt    <= fcnt_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt < MAX_C);
    end
  end

  assign mem.req_ready  = ready_q;
  assign mem.resp_valid = (fcnt != '0);
  assign mem.resp_data  = fifo[rd_ptr];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover LATENCY/
// MAX_OUTSTANDING combinations; one shared stimulus bus is steered by sel.
`timescale 1ns/1ps
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel      = 2'd0;
  logic        s_valid  = 1'b0;
  logic [31:0] s_addr   = '0;
  logic        s_we     = 1'b0;
  logic [31:0] s_wdata  = '0;
  logic [3:0]  s_be     = '0;
  logic        s_rready = 1'b1;

  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  mem_responder_if if2 ();

  assign if0.req_valid = s_valid && (sel == 2'd0);
  assign if1.req_valid = s_valid && (sel == 2'd1);
  assign if2.req_valid = s_valid && (sel == 2'd2);
  assign if0.req_addr = s_addr;   assign if1.req_addr = s_addr;   assign if2.req_addr = s_addr;
  assign if0.req_we = s_we;       assign if1.req_we = s_we;       assign if2.req_we = s_we;
  assign if0.req_wdata = s_wdata; assign if1.req_wdata = s_wdata; assign if2.req_wdata = s_wdata;
  assign if0.req_be = s_be;       assign if1.req_be = s_be;       assign if2.req_be = s_be;
  assign if0.resp_ready = s_rready;
  assign if1.resp_ready = s_rready;
  assign if2.resp_ready = s_rready;

  mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (.clk(clk), .rst(rst), .mem(if0));
  mem_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) u_bp (.clk(clk), .rst(rst), .mem(if1));
  mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(4)) u_st (.clk(clk), .rst(rst), .mem(if2));

  always_comb begin
    o_req_ready  = if0.req_ready;
    o_resp_valid = if0.resp_valid;
    o_resp_data  = if0.resp_data;
    case (sel)
      2'd1: begin o_req_ready = if1.req_ready; o_resp_valid = if1.resp_valid; o_resp_data = if1.resp_data; end
      2'd2: begin o_req_ready = if2.req_ready; o_resp_valid = if2.resp_valid; o_resp_data = if2.resp_data; end
      default: ;
    endcase
  end

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rx_q[$];
  int          rx_cyc[$];
  int          acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are decided at the next rising edge; record them mid-cycle.
  always @(negedge clk) begin
    if (rst && s_valid && o_req_ready) acc_cyc.push_back(cyc);
    if (o_resp_valid && s_rready) begin
      rx_q.push_back(o_resp_data);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rx_q.delete();
    rx_cyc.delete();
    acc_cyc.delete();
  endtask

  // Present one request and hold it until accepted; returns #1 after that edge.
  task automatic send(input logic [31:0] a, input logic we, input logic [31:0] d,
                      input logic [3:0] be);
    bit done;
    done = 1'b0;
    s_valid = 1'b1; s_addr = a; s_we = we; s_wdata = d; s_be = be;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (o_req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("send_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < 200 && rx_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    chk(tag, rx_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k); #1;
      chk("rst_req_ready", o_req_ready, 1'b0);
      chk("rst_resp_valid", o_resp_valid, 1'b0);
    end
    sel = 2'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", o_req_ready, 1'b1);
    clr();

    // ---- LATENCY=1: write then read on consecutive edges ----
    send(32'h8000_0010, 1'b1, 32'hCAFE_BABE, 4'hF);
    send(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    idle();
    drain("l1_rw_count", 2);
    chk("l1_wr_resp", rx_q[0], 32'h0);
    chk("l1_rd_resp", rx_q[1], 32'hCAFE_BABE);
    chk("l1_latency", rx_cyc[0] - acc_cyc[0], 32'd1);
    clr();

    // ---- byte enables ----
    send(32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF);
    send(32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'b0101);
    send(32'h8000_0020, 1'b0, 32'h0, 4'h0);
    idle();
    drain("be_count", 3);
    chk("be_wr_resp", rx_q[1], 32'h0);
    chk("be_rd", rx_q[2], 32'h11BB_33DD);
    clr();

    // ---- out of range: guard words first, then OOR writes and reads ----
    send(32'h8000_0000, 1'b1, 32'h0102_0304, 4'hF);
    send(32'h8000_3FFC, 1'b1, 32'h0A0B_0C0D, 4'hF);
    send(32'h7FFF_FFFC, 1'b1, 32'hDEAD_BEEF, 4'hF);
    send(32'h8000_4000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    send(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0);
    send(32'h8000_4000, 1'b0, 32'h0, 4'h0);
    send(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    send(32'h8000_3FFC, 1'b0, 32'h0, 4'h0);
    idle();
    drain("oor_count", 8);
    chk("oor_wr_lo", rx_q[2], 32'h0);
    chk("oor_wr_hi", rx_q[3], 32'h0);
    chk("oor_rd_lo", rx_q[4], 32'h0);
    chk("oor_rd_hi", rx_q[5], 32'h0);
    chk("oor_word0", rx_q[6], 32'h0102_0304);
    chk("oor_wordlast", rx_q[7], 32'h0A0B_0C0D);
    clr();

    // ---- backpressure: LATENCY=2, MAX_OUTSTANDING=2 ----
    sel = 2'd1; #1;
    send(32'h8000_0100, 1'b1, 32'd1, 4'hF);
    send(32'h8000_0104, 1'b1, 32'd2, 4'hF);
    send(32'h8000_0108, 1'b1, 32'd3, 4'hF);
    idle();
    drain("bp_pre_count", 3);
    chk("bp_latency", rx_cyc[0] - acc_cyc[0], 32'd2);
    clr();
    s_rready = 1'b0;
    s_valid = 1'b1; s_we = 1'b0; s_be = 4'h0; s_wdata = '0; s_addr = 32'h8000_0100;
    @(posedge clk); #1;
    s_addr = 32'h8000_0104;
    @(posedge clk); #1;
    s_addr = 32'h8000_0108;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_accepted", acc_cyc.size(), 32'd2);
    chk("bp_req_ready", o_req_ready, 1'b0);
    chk("bp_resp_valid", o_resp_valid, 1'b1);
    chk("bp_head_data", o_resp_data, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_head_stable", o_resp_data, 32'd1);
    s_rready = 1'b1;
    for (int k = 0; k < 20 && acc_cyc.size() < 3; k++) begin
      @(posedge clk); #1;
    end
    idle();
    drain("bp_count", 3);
    chk("bp_rsp0", rx_q[0], 32'd1);
    chk("bp_rsp1", rx_q[1], 32'd2);
    chk("bp_rsp2", rx_q[2], 32'd3);
    chk("bp_ready_back", acc_cyc[2] - rx_cyc[0], 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_dup", rx_q.size(), 32'd3);
    clr();

    // ---- streaming: LATENCY=3, MAX_OUTSTANDING=4 ----
    sel = 2'd2; #1;
    for (int i = 0; i < 16; i++) send(32'h8000_0200 + 32'(4*i), 1'b1, 32'h100 + 32'(i), 4'hF);
    idle();
    drain("st_pre_count", 16);
    clr();
    for (int i = 0; i < 16; i++) send(32'h8000_0200 + 32'(4*i), 1'b0, 32'h0, 4'h0);
    idle();
    drain("st_count", 16);
    for (int i = 0; i < 16; i++) chk($sformatf("st_rsp%0d", i), rx_q[i], 32'h100 + 32'(i));
    chk("st_latency", rx_cyc[0] - acc_cyc[0], 32'd3);
    chk("st_acc_span", acc_cyc[15] - acc_cyc[0], 32'd15);
    chk("st_rsp_span", rx_cyc[15] - rx_cyc[0], 32'd15);
    clr();

    // ---- reset mid-operation with two responses queued ----
    sel = 2'd1; #1;
    s_rready = 1'b0;
    s_valid = 1'b1; s_we = 1'b0; s_be = 4'h0; s_addr = 32'h8000_0100;
    @(posedge clk); #1;
    s_addr = 32'h8000_0104;
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("mr_queued_valid", o_resp_valid, 1'b1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mr_valid_async", o_resp_valid, 1'b0);
    chk("mr_ready_rst", o_req_ready, 1'b0);
    @(negedge clk);
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_ready_rel", o_req_ready, 1'b1);
    s_rready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mr_no_stale", rx_q.size(), 32'd0);
    send(32'h8000_0104, 1'b0, 32'h0, 4'h0);
    idle();
    drain("mr_rd_count", 1);
    chk("mr_ram_kept", rx_q[0], 32'd2);
    clr();
    sel = 2'd0; #1;
    send(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    idle();
    drain("mr_l1_count", 1);
    chk("mr_l1_ram_kept", rx_q[0], 32'hCAFE_BABE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
